// File: rtl/mac_raw_pkg.sv
// Shared definitions for the raw MAC echo block: FSM state encoding, header
// length field position, MAC/word byte constants and the payload word helper.
package mac_raw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_EMIT_HDR  = 3'd2,
        ST_EMIT_SWAP = 3'd3,
        ST_PASS      = 3'd4,
        ST_DROP      = 3'd5
    } state_e;

    // Byte length lives in the low half of the header word.
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;

    localparam int MAC_ADDR_BYTES = 6;
    localparam int RAW_WORD_BYTES = 4;

    // Words holding destination + source MAC (12 bytes -> 3 words).
    localparam int CAPTURE_WORDS = (2 * MAC_ADDR_BYTES) / RAW_WORD_BYTES;

    // Number of payload words that follow a header announcing len bytes.
    function automatic logic [15:0] payload_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'(RAW_WORD_BYTES - 1);
        return {1'b0, sum[16:2]};
    endfunction

endpackage

// File: rtl/mac_raw_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module mac_raw_sat_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;

    // Count one event per cycle with inc_i high, holding at 16'hFFFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mac_raw_echo.sv
// Raw MAC frame echo: receives length-prefixed frames, swaps destination and
// source MAC addresses and retransmits them. Out-of-range frames, or frames
// arriving while disabled, are consumed and dropped.
// Optional statistics counters are built when MAC_RAW_ECHO_STATS_EN is defined;
// otherwise the counter outputs are constant zero.
module mac_raw_echo
    import mac_raw_pkg::*;
#(
    parameter int MAX_BYTES = 9018,
    parameter int MIN_BYTES = 12
) (
    input  logic        usr_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] rx_raw_data,
    input  logic        rx_raw_sof,
    input  logic        rx_raw_dv,
    output logic        rx_raw_ack,
    output logic [31:0] tx_raw_data,
    output logic        tx_raw_sof,
    output logic        tx_raw_we,
    input  logic        tx_raw_stop,
    output logic [15:0] frames_echoed,
    output logic [15:0] frames_dropped,
    output logic [15:0] sof_errors
);

    state_e      state_q, state_d;
    logic [31:0] hdr_q, hdr_d;
    logic [31:0] w1_q, w1_d;
    logic [31:0] w2_q, w2_d;
    logic [31:0] w3_q, w3_d;
    logic [15:0] rem_q, rem_d;      // payload words still to be consumed
    logic [1:0]  idx_q, idx_d;      // capture / swap word index
    logic        run_q;             // low during reset and the first cycle after

    logic [15:0] hdr_len;
    logic [15:0] hdr_words;
    logic [31:0] hdr_len_ext;
    logic        hdr_accept;
    logic [31:0] swap_word;
    logic        inc_echo;
    logic        inc_drop;
    logic        inc_sof;

    assign hdr_len     = rx_raw_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_words   = payload_words(hdr_len);
    assign hdr_len_ext = {16'd0, hdr_len};
    // The capture stage needs at least the three MAC words to be present.
    assign hdr_accept  = enable
                      && (hdr_len_ext >= 32'(MIN_BYTES))
                      && (hdr_len_ext <= 32'(MAX_BYTES))
                      && (hdr_words >= 16'(CAPTURE_WORDS));

    // Rebuild the MAC words with source first, then destination.
    // w1={D0..D3}, w2={D4,D5,S0,S1}, w3={S2..S5}.
    always_comb begin
        case (idx_q)
            2'd0:    swap_word = {w2_q[15:0], w3_q[31:16]};   // S0..S3
            2'd1:    swap_word = {w3_q[15:0], w1_q[31:16]};   // S4,S5,D0,D1
            default: swap_word = {w1_q[15:0], w2_q[31:16]};   // D2..D5
        endcase
    end

    // Frame FSM: next state, handshakes and transmit word selection.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        w3_d        = w3_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        rx_raw_ack  = 1'b0;
        tx_raw_data = '0;
        tx_raw_sof  = 1'b0;
        tx_raw_we   = 1'b0;
        inc_echo    = 1'b0;
        inc_drop    = 1'b0;
        inc_sof     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Every word is consumed here; only a header starts a frame.
                rx_raw_ack = rx_raw_dv && run_q;
                if (rx_raw_dv && run_q && rx_raw_sof) begin
                    hdr_d   = rx_raw_data;
                    rem_d   = hdr_words;
                    idx_d   = 2'd0;
                    state_d = hdr_accept ? ST_CAPTURE : ST_DROP;
                end
            end

            ST_CAPTURE: begin
                // MAC words are taken regardless of transmit back-pressure.
                rx_raw_ack = rx_raw_dv;
                if (rx_raw_dv) begin
                    inc_sof = rx_raw_sof;
                    rem_d   = rem_q - 16'd1;
                    case (idx_q)
                        2'd0:    w1_d = rx_raw_data;
                        2'd1:    w2_d = rx_raw_data;
                        default: w3_d = rx_raw_data;
                    endcase
                    if (idx_q == 2'(CAPTURE_WORDS - 1)) begin
                        idx_d   = 2'd0;
                        state_d = ST_EMIT_HDR;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            ST_EMIT_HDR: begin
                tx_raw_data = hdr_q;
                tx_raw_sof  = 1'b1;
                tx_raw_we   = !tx_raw_stop;
                if (!tx_raw_stop) begin
                    state_d = ST_EMIT_SWAP;
                end
            end

            ST_EMIT_SWAP: begin
                tx_raw_data = swap_word;
                tx_raw_we   = !tx_raw_stop;
                if (!tx_raw_stop) begin
                    if (idx_q == 2'(CAPTURE_WORDS - 1)) begin
                        idx_d = 2'd0;
                        if (rem_q == 16'd0) begin
                            inc_echo = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            ST_PASS: begin
                // Zero-latency cut-through of the rest of the frame.
                tx_raw_data = rx_raw_data;
                tx_raw_we   = rx_raw_dv && !tx_raw_stop;
                rx_raw_ack  = rx_raw_dv && !tx_raw_stop;
                if (rx_raw_dv && !tx_raw_stop) begin
                    inc_sof = rx_raw_sof;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        inc_echo = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_DROP: begin
                if (rem_q == 16'd0) begin
                    // Header announced no payload at all.
                    inc_drop = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    rx_raw_ack = rx_raw_dv;
                    if (rx_raw_dv) begin
                        inc_sof = rx_raw_sof;
                        rem_d   = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            inc_drop = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state registers; reset abandons any frame in flight.
    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            run_q   <= 1'b1;
        end
    end

`ifdef MAC_RAW_ECHO_STATS_EN
    logic [2:0]  cnt_inc;
    logic [15:0] cnt_val [3];

    assign cnt_inc = {inc_sof, inc_drop, inc_echo};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        mac_raw_sat_cnt u_cnt (
            .clk_i  (usr_clk),
            .rst_ni (reset_n),
            .inc_i  (cnt_inc[gi]),
            .count_o(cnt_val[gi])
        );
    end

    assign frames_echoed  = cnt_val[0];
    assign frames_dropped = cnt_val[1];
    assign sof_errors     = cnt_val[2];
`else
    logic unused_stats;
    assign unused_stats   = ^{inc_echo, inc_drop, inc_sof};
    assign frames_echoed  = '0;
    assign frames_dropped = '0;
    assign sof_errors     = '0;
`endif

endmodule

// File: tb/tb_mac_raw_echo.sv
// Self-checking bench for mac_raw_echo: random payloads checked against a
// byte-level model of the MAC swap, plus directed corner cases.
module tb_mac_raw_echo;

    localparam int MAX_B = 9018;
    localparam int MIN_B = 12;
`ifdef MAC_RAW_ECHO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        usr_clk     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        enable      = 1'b0;
    logic [31:0] rx_raw_data = '0;
    logic        rx_raw_sof  = 1'b0;
    logic        rx_raw_dv   = 1'b0;
    logic        rx_raw_ack;
    logic [31:0] tx_raw_data;
    logic        tx_raw_sof;
    logic        tx_raw_we;
    logic        tx_raw_stop = 1'b0;
    logic [15:0] frames_echoed;
    logic [15:0] frames_dropped;
    logic [15:0] sof_errors;

    mac_raw_echo #(.MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) dut (
        .usr_clk       (usr_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .rx_raw_data   (rx_raw_data),
        .rx_raw_sof    (rx_raw_sof),
        .rx_raw_dv     (rx_raw_dv),
        .rx_raw_ack    (rx_raw_ack),
        .tx_raw_data   (tx_raw_data),
        .tx_raw_sof    (tx_raw_sof),
        .tx_raw_we     (tx_raw_we),
        .tx_raw_stop   (tx_raw_stop),
        .frames_echoed (frames_echoed),
        .frames_dropped(frames_dropped),
        .sof_errors    (sof_errors)
    );

    always #5 usr_clk = ~usr_clk;

    int checks = 0;
    int errors = 0;

    // Observed traffic, recorded on the falling edge.
    logic [31:0] tx_got [$];
    bit          sof_got [$];
    int          ack_cnt = 0;

    // Back-pressure control: 0 none, 1 random, 2 hold 5 cycles after header.
    int stop_mode    = 0;
    int hold_req_cnt = 0;
    int hold_ack_cnt = 0;
    int hold_left    = 0;
    int hold_cycles  = 0;
    int stop_viol    = 0;

    // Reference model state.
    int exp_echo = 0;
    int exp_drop = 0;
    int exp_sof  = 0;
    bit          fix_en = 1'b0;
    logic [31:0] fix_w [3];
    int          last_tx_base = 0;

    always @(negedge usr_clk) begin
        if (reset_n) begin
            if (tx_raw_we) begin
                tx_got.push_back(tx_raw_data);
                sof_got.push_back(tx_raw_sof);
            end
            if (rx_raw_ack) ack_cnt++;
            if (stop_mode == 2 && tx_raw_we && tx_raw_sof) hold_req_cnt++;
            if (hold_left > 0) begin
                hold_cycles++;
                if (tx_raw_we || rx_raw_ack) stop_viol++;
            end
        end
    end

    always @(posedge usr_clk) begin
        #1;
        if (hold_req_cnt != hold_ack_cnt) begin
            hold_ack_cnt = hold_req_cnt;
            hold_left    = 5;
        end else if (hold_left > 0) begin
            hold_left--;
        end
        tx_raw_stop = (hold_left > 0) || (stop_mode == 1 && $urandom_range(0, 3) == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 65535) return 16'hFFFF;
        return 16'(v);
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_echoed"},  32'(frames_echoed),  STATS ? 32'(sat16(exp_echo)) : 32'd0);
        chk({tag, "_dropped"}, 32'(frames_dropped), STATS ? 32'(sat16(exp_drop)) : 32'd0);
        chk({tag, "_sof_err"}, 32'(sof_errors),     STATS ? 32'(sat16(exp_sof))  : 32'd0);
    endtask

    // Present one word and hold it until the DUT acknowledges it.
    task automatic send_word(input logic [31:0] d, input bit s);
        bit got;
        got         = 1'b0;
        rx_raw_data = d;
        rx_raw_sof  = s;
        rx_raw_dv   = 1'b1;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge usr_clk);
            got = rx_raw_ack;
            @(posedge usr_clk);
            #1;
        end
        rx_raw_dv  = 1'b0;
        rx_raw_sof = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: observed no ack for word %h, expected ack", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge usr_clk);
        #1;
    endtask

    // Send one complete frame and compare everything against the model.
    task automatic run_frame(input logic [15:0] len, input bit en_hdr, input bit en_mid,
                             input int sof_at, input int smode);
        logic [31:0] pay [$];
        logic [31:0] exp_tx [$];
        bit          exp_sf [$];
        logic [7:0]  mac_b [12];
        logic [7:0]  out_b [12];
        logic [31:0] hdr;
        logic [31:0] t;
        int          nwords;
        bit          acc;
        int          tx_base;
        int          ack_base;
        int          n;

        nwords = (int'(len) + 3) / 4;
        acc    = en_hdr && (int'(len) >= MIN_B) && (int'(len) <= MAX_B);
        hdr    = {16'($urandom), len};
        for (int i = 0; i < nwords; i++) pay.push_back($urandom);
        if (fix_en) begin
            for (int i = 0; i < 3; i++) pay[i] = fix_w[i];
        end

        if (acc) begin
            exp_tx.push_back(hdr);
            exp_sf.push_back(1'b1);
            // Bytes 0..5 are destination, 6..11 source; output is source first.
            for (int i = 0; i < 12; i++) begin
                t        = pay[i / 4];
                mac_b[i] = t[31 - 8 * (i % 4) -: 8];
            end
            for (int i = 0; i < 6; i++) begin
                out_b[i]     = mac_b[6 + i];
                out_b[6 + i] = mac_b[i];
            end
            for (int k = 0; k < 3; k++) begin
                exp_tx.push_back({out_b[4 * k], out_b[4 * k + 1], out_b[4 * k + 2], out_b[4 * k + 3]});
                exp_sf.push_back(1'b0);
            end
            for (int i = 3; i < nwords; i++) begin
                exp_tx.push_back(pay[i]);
                exp_sf.push_back(1'b0);
            end
        end

        enable       = en_hdr;
        stop_mode    = smode;
        tx_base      = tx_got.size();
        ack_base     = ack_cnt;
        last_tx_base = tx_base;

        send_word(hdr, 1'b1);
        enable = en_mid;
        for (int i = 0; i < nwords; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_word(pay[i], (i == sof_at));
        end
        for (int c = 0; c < 100 && (tx_got.size() - tx_base) < exp_tx.size(); c++) idle(1);
        idle(4);
        stop_mode = 0;

        if (acc) exp_echo++;
        else     exp_drop++;
        if (sof_at >= 0 && sof_at < nwords) exp_sof++;

        $display("frame len=%0d en=%0d accepted=%0d tx_words=%0d acks=%0d", len, en_hdr, acc,
                 tx_got.size() - tx_base, ack_cnt - ack_base);

        chk("tx_count", 32'(tx_got.size() - tx_base), 32'(exp_tx.size()));
        n = exp_tx.size();
        if ((tx_got.size() - tx_base) < n) n = tx_got.size() - tx_base;
        for (int i = 0; i < n; i++) begin
            chk("tx_word", tx_got[tx_base + i], exp_tx[i]);
            chk("tx_sof", 32'(sof_got[tx_base + i]), 32'(exp_sf[i]));
        end
        chk("ack_count", 32'(ack_cnt - ack_base), 32'(1 + nwords));
        chk_counters("cnt");
    endtask

    initial begin
        int hc0;
        int sv0;
        int tb0;
        int ab0;
        logic [31:0] pw;
        int rl;

        // Reset with traffic present: everything must stay quiet.
        enable      = 1'b1;
        rx_raw_dv   = 1'b1;
        rx_raw_sof  = 1'b1;
        rx_raw_data = 32'h0000_0040;
        idle(3);
        chk("rst_ack", 32'(rx_raw_ack), 32'd0);
        chk("rst_we", 32'(tx_raw_we), 32'd0);
        chk("rst_sof", 32'(tx_raw_sof), 32'd0);
        chk("rst_data", tx_raw_data, 32'd0);
        chk("rst_echoed", 32'(frames_echoed), 32'd0);
        chk("rst_dropped", 32'(frames_dropped), 32'd0);
        chk("rst_sof_err", 32'(sof_errors), 32'd0);
        rx_raw_dv  = 1'b0;
        rx_raw_sof = 1'b0;
        @(negedge usr_clk);
        reset_n = 1'b1;
        idle(2);

        // Reference echo frame with the documented MAC words.
        fix_en   = 1'b1;
        fix_w[0] = 32'h0011_2233;
        fix_w[1] = 32'h4455_0A0B;
        fix_w[2] = 32'h0C0D_0E0F;
        run_frame(16'd64, 1'b1, 1'b1, -1, 0);
        chk("ref_sw0", tx_got[last_tx_base + 1], 32'h0A0B_0C0D);
        chk("ref_sw1", tx_got[last_tx_base + 2], 32'h0E0F_0011);
        chk("ref_sw2", tx_got[last_tx_base + 3], 32'h2233_4455);

        // Same frame with transmit held off for 5 cycles during the swap.
        hc0 = hold_cycles;
        sv0 = stop_viol;
        run_frame(16'd64, 1'b1, 1'b1, -1, 2);
        chk("hold_cycles", 32'(hold_cycles - hc0), 32'd5);
        chk("hold_no_handshake", 32'(stop_viol - sv0), 32'd0);
        chk("hold_sw0", tx_got[last_tx_base + 1], 32'h0A0B_0C0D);
        fix_en = 1'b0;

        // Length out of range on both sides.
        run_frame(16'd8, 1'b1, 1'b1, -1, 0);
        run_frame(16'd9019, 1'b1, 1'b1, -1, 1);

        // Disabled frame, enable raised mid-frame, then an echoed frame.
        run_frame(16'd64, 1'b0, 1'b0, -1, 0);
        run_frame(16'd64, 1'b0, 1'b1, -1, 0);
        run_frame(16'd64, 1'b1, 1'b1, -1, 0);

        // Stray sof on payload word 7.
        run_frame(16'd64, 1'b1, 1'b1, 6, 1);

        // Boundaries: minimum, just below, empty, maximum, first pass word.
        run_frame(16'd12, 1'b1, 1'b1, -1, 1);
        run_frame(16'd11, 1'b1, 1'b1, -1, 0);
        run_frame(16'd0, 1'b1, 1'b1, -1, 0);
        run_frame(16'd13, 1'b1, 1'b1, -1, 1);
        run_frame(16'd9018, 1'b1, 1'b1, -1, 1);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            rl = $urandom_range(4, 160);
            run_frame(16'(rl), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : -1,
                      int'($urandom_range(0, 1)));
        end

        // Reset in the middle of the pass-through phase.
        enable = 1'b1;
        send_word({16'h5A5A, 16'd64}, 1'b1);
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
        pw          = $urandom;
        rx_raw_data = pw;
        rx_raw_dv   = 1'b1;
        #1;
        chk("pass_ack", 32'(rx_raw_ack), 32'd1);
        chk("pass_data", tx_raw_data, pw);
        reset_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(rx_raw_ack), 32'd0);
        chk("midrst_we", 32'(tx_raw_we), 32'd0);
        chk("midrst_sof", 32'(tx_raw_sof), 32'd0);
        chk("midrst_data", tx_raw_data, 32'd0);
        exp_echo = 0;
        exp_drop = 0;
        exp_sof  = 0;
        chk_counters("midrst");
        rx_raw_dv = 1'b0;
        @(posedge usr_clk);
        @(negedge usr_clk);
        reset_n = 1'b1;
        idle(2);

        // Leftover words of the abandoned frame are swallowed silently.
        tb0 = tx_got.size();
        ab0 = ack_cnt;
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        idle(3);
        chk("residual_tx", 32'(tx_got.size() - tb0), 32'd0);
        chk("residual_ack", 32'(ack_cnt - ab0), 32'd2);

        run_frame(16'd64, 1'b1, 1'b1, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed simulation still running, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
